// File: rtl/conv1_ofm_writer.sv
// conv1_ofm_writer: captures one conv1 pixel of DSP_NO channels and streams it to BANKS feature-map RAM ports.
module conv1_ofm_writer #(
  parameter int DSP_NO     = 64,
  parameter int BANKS      = 4,
  parameter int WOUT       = 128,
  parameter int SKIP_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conv1_sample,
  input  logic [DSP_NO*16-1:0]    ofm,
  output logic [BANKS-1:0]        wr_en,
  output logic [17:0]             wr_addr,
  output logic [BANKS*16-1:0]     wr_data,
  output logic                    busy,
  output logic                    overrun,
  output logic                    ram_feedback
);
  localparam int LPB = DSP_NO / BANKS;
  localparam int PIX = WOUT * WOUT;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t                state_q, state_d;
  logic [13:0]           pixel_q, pixel_d;
  logic [3:0]            slot_q, slot_d;
  logic                  skip_q, skip_d;
  logic                  overrun_q, overrun_d;
  logic                  cap;
  logic [DSP_NO*16-1:0]  buf_q, buf_d;
  logic [BANKS-1:0]      wr_en_q, wr_en_d;
  logic [17:0]           wr_addr_q, wr_addr_d;
  logic [BANKS*16-1:0]   wr_data_q, wr_data_d;
  // Outputs are registered from next-state values so the first beat lands the cycle after capture.
  always_comb begin
    state_d   = state_q;
    pixel_d   = pixel_q;
    slot_d    = slot_q;
    skip_d    = skip_q;
    overrun_d = overrun_q;
    cap       = 1'b0;
    case (state_q)
      IDLE: if (conv1_sample) begin
        if (skip_q) skip_d = 1'b0;
        else begin
          cap     = 1'b1;
          slot_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: if (slot_q == 4'(LPB - 1)) begin
        pixel_d = pixel_q + 14'd1;
        slot_d  = '0;
        cap     = conv1_sample && (pixel_q != 14'(PIX - 1));
        state_d = (pixel_q == 14'(PIX - 1)) ? DONE : cap ? WRITE : IDLE;
      end else begin
        slot_d    = slot_q + 4'd1;
        overrun_d = overrun_q | conv1_sample;
      end
      default: ;
    endcase
    buf_d     = cap ? ofm : buf_q;
    wr_en_d   = (state_d == WRITE) ? '1 : '0;
    wr_addr_d = (state_d == WRITE) ? 18'(slot_d) * 18'(PIX) + 18'(pixel_d) : wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_d == WRITE)
      for (int b = 0; b < BANKS; b++)
        wr_data_d[b*16 +: 16] = buf_d[(b*LPB + int'(slot_d))*16 +: 16];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pixel_q   <= '0;
      slot_q    <= '0;
      skip_q    <= 1'(SKIP_FIRST);
      overrun_q <= 1'b0;
      buf_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pixel_q   <= pixel_d;
      slot_q    <= slot_d;
      skip_q    <= skip_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = (state_q == WRITE);
  assign overrun      = overrun_q;
  assign ram_feedback = (state_q == DONE);
endmodule
